// File: rtl/input_proc_2.sv
// Frame-buffer write side: thresholds the DVI luma stream to 1 bpp, packs 8 pixels per byte
// (MSB = leftmost) and writes vertically decimated lines into the frame RAM.
module input_proc_2 #(
  parameter int SCREEN_WIDTH  = 80,
  parameter int SCREEN_HEIGHT = 240,
  parameter int LINE_DIV      = 2
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        de,
  input  logic        vs,
  input  logic [7:0]  pixIn,
  input  logic [7:0]  threshold,
  output logic [14:0] wrAddr,
  output logic [7:0]  wrData,
  output logic        wrEn,
  output logic        frameDone
);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    WAIT_LINE = 2'd1,
    ACTIVE    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0] X_END     = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0] Y_END     = YW'(SCREEN_HEIGHT);
  localparam logic [14:0]   LAST_ADDR = 15'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
  localparam logic [15:0]   LDIV      = 16'(LINE_DIV);

  state_t          state_q, state_d;
  logic            vs_q, vs_prev_q, de_q, de_prev_q;
  logic [7:0]      pix_q;
  logic [XW-1:0]   byte_x_q, byte_x_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     src_line_q, src_line_d;
  logic [YW-1:0]   line_y_q, line_y_d;
  logic [7:0]      shift_q, shift_d;
  logic [14:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;
  logic            frame_done_q, frame_done_d;

  logic            vs_rise_s, de_rise_s, de_fall_s;
  logic            line_kept_s, line_on_s, x_ok_s, take_pix_s, pix_bit_s;
  logic [14:0]     cur_addr_s;
  logic [3:0]      flush_sh_s;

  assign vs_rise_s   = vs_q & ~vs_prev_q;
  assign de_rise_s   = de_q & ~de_prev_q;
  assign de_fall_s   = ~de_q & de_prev_q;
  assign line_kept_s = (src_line_q % LDIV) == 16'd0;
  assign x_ok_s      = byte_x_q < X_END;
  // The deRise cycle already carries the first pixel, so it counts as active.
  assign line_on_s   = (state_q == ACTIVE) ||
                       ((state_q == WAIT_LINE) && de_rise_s && (line_y_q < Y_END));
  assign take_pix_s  = line_on_s && de_q && line_kept_s && x_ok_s && !vs_rise_s;
  assign pix_bit_s   = pix_q > threshold;
  assign cur_addr_s  = 15'(byte_x_q) + 15'(line_y_q) * 15'(SCREEN_WIDTH);
  assign flush_sh_s  = 4'd8 - {1'b0, bit_cnt_q};

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= UNLOCKED;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      de_q         <= 1'b0;
      de_prev_q    <= 1'b0;
      pix_q        <= 8'd0;
      byte_x_q     <= '0;
      bit_cnt_q    <= 3'd0;
      src_line_q   <= 16'd0;
      line_y_q     <= '0;
      shift_q      <= 8'd0;
      wr_addr_q    <= 15'd0;
      wr_data_q    <= 8'd0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs;
      vs_prev_q    <= vs_q;
      de_q         <= de;
      de_prev_q    <= de_q;
      pix_q        <= pixIn;
      byte_x_q     <= byte_x_d;
      bit_cnt_q    <= bit_cnt_d;
      src_line_q   <= src_line_d;
      line_y_q     <= line_y_d;
      shift_q      <= shift_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (vs_rise_s) begin
      state_d = WAIT_LINE;
    end else begin
      case (state_q)
        UNLOCKED:  state_d = UNLOCKED;
        WAIT_LINE: begin
          if (line_y_q >= Y_END) state_d = DONE;
          else if (de_rise_s)    state_d = ACTIVE;
          else                   state_d = WAIT_LINE;
        end
        ACTIVE:    state_d = de_fall_s ? WAIT_LINE : ACTIVE;
        DONE:      state_d = DONE;
        default:   state_d = UNLOCKED;
      endcase
    end
  end

  // Pixel packing, line bookkeeping and write-port generation.
  always_comb begin
    byte_x_d   = byte_x_q;
    bit_cnt_d  = bit_cnt_q;
    src_line_d = src_line_q;
    line_y_d   = line_y_q;
    shift_d    = shift_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    if (vs_rise_s) begin
      byte_x_d   = '0;
      bit_cnt_d  = 3'd0;
      src_line_d = 16'd0;
      line_y_d   = '0;
      shift_d    = 8'd0;
    end else if (take_pix_s) begin
      shift_d   = {shift_q[6:0], pix_bit_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        wr_en_d   = 1'b1;
        wr_data_d = {shift_q[6:0], pix_bit_s};
        wr_addr_d = cur_addr_s;
        byte_x_d  = byte_x_q + XW'(1);
      end else begin
        byte_x_d  = byte_x_q;
      end
    end else if ((state_q == ACTIVE) && de_fall_s) begin
      // Partial byte is left-aligned so the unused LSBs read as unlit.
      if (line_kept_s && (bit_cnt_q != 3'd0) && x_ok_s) begin
        wr_en_d   = 1'b1;
        wr_data_d = shift_q << flush_sh_s;
        wr_addr_d = cur_addr_s;
      end else begin
        wr_en_d   = 1'b0;
      end
      src_line_d = src_line_q + 16'd1;
      if (line_kept_s) begin
        line_y_d  = line_y_q + YW'(1);
        byte_x_d  = '0;
        bit_cnt_d = 3'd0;
        shift_d   = 8'd0;
      end else begin
        line_y_d  = line_y_q;
      end
    end else begin
      wr_en_d = 1'b0;
    end
    frame_done_d = wr_en_d && (wr_addr_d == LAST_ADDR);
  end

  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;
  assign wrEn      = wr_en_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_input_proc_2.sv
// Scoreboard bench for input_proc_2; frame height is shortened to keep full frames cheap,
// while the line width stays at the real 80 bytes.
module tb_input_proc_2;

  localparam int W = 80;
  localparam int H = 8;
  localparam int SRC_LINES = H * 2;

  logic        clk = 1'b0;
  logic        rst_n, de, vs;
  logic [7:0]  pix, thr;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en, frame_done;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
    logic        f;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0, errors = 0;
  int  wr_count = 0, fd_count = 0, cyc = 0;
  int  p8_cyc = -1, first_wr_cyc = -1, base;
  bit  lat_arm = 1'b0, cap_p8 = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  input_proc_2 #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .LINE_DIV(2)) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .de       (de),
    .vs       (vs),
    .pixIn    (pix),
    .threshold(thr),
    .wrAddr   (wr_addr),
    .wrData   (wr_data),
    .wrEn     (wr_en),
    .frameDone(frame_done)
  );

  function automatic logic [7:0] pix_of(int pat, int x);
    case (pat)
      0:       return (x % 2 == 0) ? 8'hFF : 8'h00;
      1:       return 8'hFF;
      2:       return 8'h00;
      3:       return (x % 2 == 0) ? 8'h80 : 8'h81;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int src_pat(int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    if (k == 2) return 2;
    return (k % 2 == 1) ? 1 : 3;
  endfunction

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic exp_push(int a, logic [7:0] d);
    wr_t e;
    e.a = 15'(a);
    e.d = d;
    e.f = (a == W * H - 1);
    exp_q.push_back(e);
  endtask

  task automatic exp_line(int y, int n, logic [7:0] d);
    for (int i = 0; i < n; i++) exp_push(y * W + i, d);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      de = 1'b0;
    end
  endtask

  task automatic send_line(int npix, int pat);
    for (int x = 0; x < npix; x++) begin
      @(negedge clk);
      de  = 1'b1;
      pix = pix_of(pat, x);
      if (x == 7 && cap_p8) begin
        p8_cyc = cyc;
        cap_p8 = 1'b0;
      end
    end
    @(negedge clk);
    de  = 1'b0;
    pix = 8'h00;
    idle(4);
  endtask

  task automatic pulse_vs();
    @(negedge clk); vs = 1'b1;
    @(negedge clk); vs = 1'b1;
    @(negedge clk); vs = 1'b0;
    idle(3);
  endtask

  task automatic drain(string name);
    idle(6);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; de = 1'b0; vs = 1'b0; pix = 8'h00; thr = 8'h80;
    fork
      // Monitor: every write strobe must match the head of the expected queue.
      forever begin
        wr_t e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
          wr_count++;
          if (frame_done === 1'b1) fd_count++;
          if (lat_arm && first_wr_cyc < 0) first_wr_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%02h", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            if (wr_addr !== e.a || wr_data !== e.d || frame_done !== e.f) begin
              errors++;
              $display("FAIL write got addr=%0d data=%02h fd=%0b want addr=%0d data=%02h fd=%0b",
                       wr_addr, wr_data, frame_done, e.a, e.d, e.f);
            end
          end
        end else if (frame_done !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL frame_done_without_write got=%0b want=0", frame_done);
        end
      end
      begin
        repeat (3) @(negedge clk);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        idle(2);

        // Whole frame before any vs: nothing may be written.
        for (int k = 0; k < SRC_LINES; k++) send_line(640, 1);
        drain("unlocked_drain");
        check("unlocked_count", wr_count, 0);

        // Locked frame: line0 0xAA, line1 skipped, line2 zeros, rest threshold-edge 0x55.
        pulse_vs();
        base = wr_count;
        exp_line(0, W, 8'hAA);
        exp_line(1, W, 8'h00);
        for (int y = 2; y < H; y++) exp_line(y, W, 8'h55);
        cap_p8 = 1'b1;
        lat_arm = 1'b1;
        for (int k = 0; k < SRC_LINES; k++) send_line(640, src_pat(k));
        drain("frame_drain");
        lat_arm = 1'b0;
        check("frame_count", wr_count - base, W * H);
        check("frame_done_pulses", fd_count, 1);
        check("first_wr_latency", first_wr_cyc - p8_cyc, 2);

        // Frame complete: further lines are ignored.
        base = wr_count;
        send_line(640, 1);
        send_line(640, 1);
        drain("done_drain");
        check("done_count", wr_count - base, 0);

        // Short line flush, skipped line, over-long line truncation.
        pulse_vs();
        base = wr_count;
        exp_push(0, 8'hFF);
        exp_push(1, 8'hF8);
        send_line(13, 1);
        send_line(8, 1);
        exp_line(1, W, 8'hFF);
        send_line(700, 1);
        drain("short_long_drain");
        check("short_long_count", wr_count - base, 82);

        // vs mid-frame restarts addressing at 0.
        pulse_vs();
        for (int k = 0; k < 7; k++) begin
          if (k % 2 == 0) begin
            exp_push((k / 2) * W, 8'hFF);
            exp_push((k / 2) * W + 1, 8'hFF);
          end
          send_line(16, 1);
        end
        pulse_vs();
        exp_push(0, 8'hFF);
        send_line(8, 1);
        drain("mid_vs_drain");

        // Reset in the middle of a line, just after a write.
        pulse_vs();
        exp_push(0, 8'hFF);
        for (int x = 0; x < 8; x++) begin
          @(negedge clk);
          de = 1'b1;
          pix = 8'hFF;
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", int'(wr_en), 0);
        check("midrst_wr_data", int'(wr_data), 0);
        check("midrst_wr_addr", int'(wr_addr), 0);
        @(negedge clk);
        de = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        base = wr_count;
        send_line(16, 1);
        drain("post_rst_drain");
        check("post_rst_count", wr_count - base, 0);
        pulse_vs();
        exp_push(0, 8'hFF);
        send_line(8, 1);
        drain("relock_drain");
        check("total_frame_done", fd_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end

endmodule
